// File: rtl/muldiv_pkg.sv
// Shared encodings, states and the per-operation context for the multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ITER_N = 32;
  localparam int unsigned CNT_W  = $clog2(ITER_N);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL_IT = 3'd1,
    ST_DIV_IT = 3'd2,
    ST_FIX    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Captured at acceptance: what FIX needs to turn magnitudes into HI/LO.
  typedef struct packed {
    logic            is_div;
    logic            div_zero;
    logic            neg_lo;   // product or quotient is negative
    logic            neg_hi;   // remainder is negative
    logic [XLEN-1:0] a;        // raw dividend, returned in HI on divide-by-zero
  } ctx_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the CPU pipeline and the multiply/divide controller.
interface muldiv_ctrl_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, req_op, req_a, req_b, cancel,
    input  req_ready, busy, done, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, cancel,
    output req_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative datapath: shift-add multiply and restoring divide on a 64-bit accumulator.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*WIDTH-1:0] load_acc,
  input  logic [WIDTH-1:0]   load_opnd,
  input  logic               step,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc
);

  localparam int unsigned DW = 2 * WIDTH;

  logic [DW-1:0]    acc_q, acc_step;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;

  // One iteration: multiply adds into the upper half and shifts right,
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q};
    div_shift = acc_q[DW-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opnd_q};
    acc_step  = acc_q;
    if (is_div) begin
      if (!div_trial[WIDTH]) acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                   acc_step = {acc_q[DW-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_step = {1'b0, acc_q[DW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load) begin
      acc_q  <= load_acc;
      opnd_q <= load_opnd;
    end else if (step) begin
      acc_q  <= acc_step;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS-style HI/LO multiply/divide controller: FSM, iteration counter, sign fix-up, HI/LO.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply (IDLE -> FIX); divide stays iterative.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int unsigned DW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  ctx_t             ctx_q, ctx_d;

  logic             it_load, it_step;
  logic [DW-1:0]    it_load_acc, it_acc, prod;
  logic [WIDTH-1:0] it_load_opnd;
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Magnitudes of the request on the bus, and the signed product seen by FIX.
  always_comb begin
    op_signed = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);
    a_neg     = op_signed && bus.req_a[WIDTH-1];
    b_neg     = op_signed && bus.req_b[WIDTH-1];
    mag_a     = a_neg ? -bus.req_a : bus.req_a;
    mag_b     = b_neg ? -bus.req_b : bus.req_b;
    prod      = ctx_q.neg_lo ? -it_acc : it_acc;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (it_load),
    .load_acc  (it_load_acc),
    .load_opnd (it_load_opnd),
    .step      (it_step),
    .is_div    (state_q == ST_DIV_IT),
    .acc       (it_acc)
  );

  // Next-state, counter, HI/LO and datapath control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    ctx_d        = ctx_q;
    it_load      = 1'b0;
    it_step      = 1'b0;
    it_load_acc  = '0;
    it_load_opnd = '0;

    if (bus.cancel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            case (bus.req_op)
              OP_MULT, OP_MULTU: begin
                ctx_d   = '{is_div: 1'b0, div_zero: 1'b0, neg_lo: a_neg ^ b_neg,
                            neg_hi: a_neg, a: bus.req_a};
                it_load = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                it_load_acc = DW'(mag_a) * DW'(mag_b);
                state_d     = ST_FIX;
`else
                it_load_acc  = {{WIDTH{1'b0}}, mag_b};
                it_load_opnd = mag_a;
                cnt_d        = CNT_W'(ITER_N - 1);
                state_d      = ST_MUL_IT;
`endif
              end
              OP_DIV, OP_DIVU: begin
                ctx_d        = '{is_div: 1'b1, div_zero: (bus.req_b == '0),
                                 neg_lo: a_neg ^ b_neg, neg_hi: a_neg, a: bus.req_a};
                it_load      = 1'b1;
                it_load_acc  = {{WIDTH{1'b0}}, mag_a};
                it_load_opnd = mag_b;
                cnt_d        = CNT_W'(ITER_N - 1);
                state_d      = ST_DIV_IT;
              end
              OP_MTHI: begin
                hi_d   = bus.req_a;
                done_d = 1'b1;
              end
              OP_MTLO: begin
                lo_d   = bus.req_a;
                done_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MUL_IT, ST_DIV_IT: begin
          it_step = 1'b1;
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_FIX: begin
          if (!ctx_q.is_div) begin
            hi_d = prod[DW-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (ctx_q.div_zero) begin
            hi_d = ctx_q.a;
            lo_d = '1;
          end else begin
            hi_d = ctx_q.neg_hi ? -it_acc[DW-1:WIDTH] : it_acc[DW-1:WIDTH];
            lo_d = ctx_q.neg_lo ? -it_acc[WIDTH-1:0]  : it_acc[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      ctx_q   <= ctx_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected HI/LO, a monitor checks on done.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
  localparam int MUL_BSY = 1;
`else
  localparam int MUL_LAT = 34;
  localparam int MUL_BSY = 33;
`endif
  localparam int DIV_LAT = 34;
  localparam int DIV_BSY = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=hi:%h lo:%h required=no done", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
        chk({t, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
      end
    end
  end

  // Issue one request at the next falling edge; optionally expect a result and time it.
  task automatic do_op(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input int bsy, input bit wait_done);
    int n;
    int nb;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    if (!wait_done) return;
    exp_q.push_back({eh, el});
    tag_q.push_back(tag);
    m_hi = eh;
    m_lo = el;
    n  = 0;
    nb = 0;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (bus.busy) nb++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(bsy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.cancel    = 1'b0;

    #3;
    chk("rst_hi",    64'(bus.hi),        64'd0);
    chk("rst_lo",    64'(bus.lo),        64'd0);
    chk("rst_done",  64'(bus.done),      64'd0);
    chk("rst_busy",  64'(bus.busy),      64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    do_op("mult_neg2x3",  OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT, MUL_BSY, 1);
    do_op("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, MUL_BSY, 1);
    do_op("multu_shift",  OP_MULTU, 32'h12345678, 32'h100,      32'h00000012, 32'h34567800, MUL_LAT, MUL_BSY, 1);
    do_op("div_neg7by2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, DIV_BSY, 1);
    do_op("divu_by0",     OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, DIV_LAT, DIV_BSY, 1);
    do_op("div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT, DIV_BSY, 1);
    do_op("div_100byn7",  OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, DIV_LAT, DIV_BSY, 1);
    do_op("mtlo",         OP_MTLO,  32'h12345678, 32'd0,        m_hi,         32'h12345678, 1, 0, 1);

    // NOP codes: accepted, no state change, no done, HI/LO untouched.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op_e'(3'd7);
    bus.req_a     = 32'hDEADBEEF;
    @(negedge clk);
    bus.req_op    = OP_NOP;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("nop_busy", 64'(bus.busy), 64'd0);
    chk("nop_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Cancel a divide mid-iteration while a second request waits on a busy controller.
    do_op("mthi_a5", OP_MTHI, 32'hA5A5A5A5, 32'd0, 32'hA5A5A5A5, m_lo,         1, 0, 1);
    do_op("mtlo_a5", OP_MTLO, 32'hA5A5A5A5, 32'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 0, 1);
    do_op("div_cancel", OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, 0);
    repeat (5) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_MULT;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'd3;
    chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("pre_cancel_busy", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel    = 1'b0;
    bus.req_valid = 1'b0;
    chk("cancel_busy",  64'(bus.busy),      64'd0);
    chk("cancel_ready", 64'(bus.req_ready), 64'd1);
    chk("cancel_hilo",  {bus.hi, bus.lo},   {32'hA5A5A5A5, 32'hA5A5A5A5});
    repeat (3) @(negedge clk);
    chk("cancel_idle_busy", 64'(bus.busy), 64'd0);

    // Cancel beats a request arriving in IDLE.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_MTLO;
    bus.req_a     = 32'd0;
    bus.cancel    = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.cancel    = 1'b0;
    @(negedge clk);
    chk("cancel_vs_req_lo",   64'(bus.lo),   64'hA5A5A5A5);
    chk("cancel_vs_req_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    do_op("mult_reset", OP_MULT, 32'd5, 32'd6, 32'd0, 32'd0, 0, 0, 0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy",  64'(bus.busy),      64'd0);
    chk("async_rst_hilo",  {bus.hi, bus.lo},   64'd0);
    chk("async_rst_ready", 64'(bus.req_ready), 64'd1);
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_op("multu_after_rst", OP_MULTU, 32'h12345678, 32'h100, 32'h00000012, 32'h34567800, MUL_LAT, MUL_BSY, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
